stopwatch_sseg: RTL and testbench

Four-digit stopwatch (00.00–99.99 s, 10 ms resolution) that produces the four 8-bit segment patterns consumed by the time-multiplexed display driver `disp_mux`. It sits directly upstream of that driver: its `sseg3..sseg0` outputs connect to the driver's `in3..in0`. It contains a programmable prescaler, a cascaded BCD counter chain with carry logic, and registered active-low segment encoding.

---
 rtl/stopwatch_sseg.sv | 132 +++++++++++++
 tb/tb_stopwatch_sseg.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_sseg.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_sseg
// Description : 00.00-99.99 s stopwatch (programmable prescaler, cascaded BCD
//               counters) with registered active-low seven-segment patterns.
//               Optional build macro: STOPWATCH_LEAD_BLANK_EN (blank sseg3
//               while the tens-of-seconds digit is zero).
// Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_sseg #(
    parameter int DIV = 500_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       go,
    input  logic       clr,
    output logic [3:0] d3,
    output logic [3:0] d2,
    output logic [3:0] d1,
    output logic [3:0] d0,
    output logic [7:0] sseg3,
    output logic [7:0] sseg2,
    output logic [7:0] sseg1,
    output logic [7:0] sseg0,
    output logic       wrap
);

    localparam int              c_PW     = $clog2(DIV);
    localparam logic [c_PW-1:0] c_P_LAST = c_PW'(DIV - 1);
    localparam logic [7:0]      c_SEG_0  = 8'hC0;
    localparam logic [7:0]      c_BLANK  = 8'hFF;

    logic [c_PW-1:0] r_p;
    logic [3:0][3:0] r_d;
    logic            r_wrap;
    logic [7:0]      r_sseg3;
    logic [7:0]      r_sseg2;
    logic [7:0]      r_sseg1;
    logic [7:0]      r_sseg0;

    logic            w_tick;
    logic [3:0]      w_nine;
    logic [4:0]      w_c;
    logic [3:0][3:0] w_d_nxt;

    function automatic logic [7:0] f_enc(input logic [3:0] dig);
        case (dig)
            4'd0:    f_enc = 8'hC0;
            4'd1:    f_enc = 8'hF9;
            4'd2:    f_enc = 8'hA4;
            4'd3:    f_enc = 8'hB0;
            4'd4:    f_enc = 8'h99;
            4'd5:    f_enc = 8'h92;
            4'd6:    f_enc = 8'h82;
            4'd7:    f_enc = 8'hF8;
            4'd8:    f_enc = 8'h80;
            4'd9:    f_enc = 8'h90;
            default: f_enc = 8'hFF;
        endcase
    endfunction

    assign w_tick = (r_p == c_P_LAST) && go;

    // Carry into digit i is the tick gated by every lower digit being 9;
    // w_c[4] is the full-scale rollover.
    assign w_c = {w_tick & (&w_nine[3:0]),
                  w_tick & (&w_nine[2:0]),
                  w_tick & (&w_nine[1:0]),
                  w_tick & w_nine[0],
                  w_tick};

    generate
        for (genvar i = 0; i < 4; i++) begin : g_digit
            assign w_nine[i]  = (r_d[i] == 4'd9);
            assign w_d_nxt[i] = !w_c[i]   ? r_d[i] :
                                w_nine[i] ? 4'd0   : r_d[i] + 4'd1;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_p    <= '0;
            r_d    <= '0;
            r_wrap <= 1'b0;
        end else if (clr) begin
            r_p    <= '0;
            r_d    <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_c[4];
            r_d    <= w_d_nxt;
            if (go) begin
                r_p <= w_tick ? '0 : r_p + c_PW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
`ifdef STOPWATCH_LEAD_BLANK_EN
            r_sseg3 <= c_BLANK;
`else
            r_sseg3 <= c_SEG_0;
`endif
            r_sseg2 <= c_SEG_0 & 8'h7F;
            r_sseg1 <= c_SEG_0;
            r_sseg0 <= c_SEG_0;
        end else begin
`ifdef STOPWATCH_LEAD_BLANK_EN
            r_sseg3 <= (r_d[3] == 4'd0) ? c_BLANK : f_enc(r_d[3]);
`else
            r_sseg3 <= f_enc(r_d[3]);
`endif
            // Decimal point sits after the units-of-seconds digit.
            r_sseg2 <= f_enc(r_d[2]) & 8'h7F;
            r_sseg1 <= f_enc(r_d[1]);
            r_sseg0 <= f_enc(r_d[0]);
        end
    end

    assign d3    = r_d[3];
    assign d2    = r_d[2];
    assign d1    = r_d[1];
    assign d0    = r_d[0];
    assign wrap  = r_wrap;
    assign sseg3 = r_sseg3;
    assign sseg2 = r_sseg2;
    assign sseg1 = r_sseg1;
    assign sseg0 = r_sseg0;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_sseg.sv
`default_nettype none
// ============================================================================
// Module      : tb_stopwatch_sseg
// Description : Self-checking bench for stopwatch_sseg (DIV = 4) against an
//               integer-count reference model; honours STOPWATCH_LEAD_BLANK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_sseg;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       go;
    logic       clr;
    logic [3:0] d3, d2, d1, d0;
    logic [7:0] sseg3, sseg2, sseg1, sseg0;
    logic       wrap;

    stopwatch_sseg #(.DIV(DIV)) dut (
        .clk   (clk),
        .reset (reset),
        .go    (go),
        .clr   (clr),
        .d3    (d3),
        .d2    (d2),
        .d1    (d1),
        .d0    (d0),
        .sseg3 (sseg3),
        .sseg2 (sseg2),
        .sseg1 (sseg1),
        .sseg0 (sseg0),
        .wrap  (wrap)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: elapsed time as an integer number of hundredths.
    int         m_cnt;
    int         m_p;
    bit         m_wrap;
    logic [7:0] m_s3, m_s2, m_s1, m_s0;
    logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                  8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    function automatic int dig(int n, int k);
        case (k)
            0:       dig = n % 10;
            1:       dig = (n / 10) % 10;
            2:       dig = (n / 100) % 10;
            default: dig = (n / 1000) % 10;
        endcase
    endfunction

    function automatic logic [15:0] bcd(int n);
        bcd = {4'(dig(n, 3)), 4'(dig(n, 2)), 4'(dig(n, 1)), 4'(dig(n, 0))};
    endfunction

    function automatic logic [7:0] exp_s3(int n);
`ifdef STOPWATCH_LEAD_BLANK_EN
        exp_s3 = (dig(n, 3) == 0) ? 8'hFF : seg_tab[dig(n, 3)];
`else
        exp_s3 = seg_tab[dig(n, 3)];
`endif
    endfunction

    task automatic model_reset();
        m_cnt  = 0;
        m_p    = 0;
        m_wrap = 0;
        m_s3   = exp_s3(0);
        m_s2   = 8'h40;
        m_s1   = 8'hC0;
        m_s0   = 8'hC0;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_all(string tag);
        chk({tag, "_digits"}, {16'h0, d3, d2, d1, d0}, {16'h0, bcd(m_cnt)});
        chk({tag, "_sseg"}, {sseg3, sseg2, sseg1, sseg0}, {m_s3, m_s2, m_s1, m_s0});
        chk({tag, "_wrap"}, {31'h0, wrap}, {31'h0, m_wrap});
    endtask

    // One clock: update the model with the inputs sampled at the edge, then
    // compare all outputs 1 ns later.
    task automatic step(string tag);
        int old;
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            old  = m_cnt;
            m_s3 = exp_s3(old);
            m_s2 = seg_tab[dig(old, 2)] & 8'h7F;
            m_s1 = seg_tab[dig(old, 1)];
            m_s0 = seg_tab[dig(old, 0)];
            if (clr) begin
                m_p = 0; m_cnt = 0; m_wrap = 0;
            end else if (go && m_p == DIV - 1) begin
                m_p = 0; m_wrap = (old == 9999); m_cnt = (old + 1) % 10000;
            end else begin
                if (go) m_p++;
                m_wrap = 0;
            end
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        int saved;
        int nwrap;
        reset = 1'b1;
        go    = 1'b0;
        clr   = 1'b0;
        model_reset();

        // Reset held two cycles.
        step("reset");
        step("reset");
`ifdef STOPWATCH_LEAD_BLANK_EN
        chk("reset_sseg_const", {sseg3, sseg2, sseg1, sseg0}, 32'hFF40C0C0);
`else
        chk("reset_sseg_const", {sseg3, sseg2, sseg1, sseg0}, 32'hC040C0C0);
`endif

        // Counting from release.
        reset = 1'b0;
        go    = 1'b1;
        repeat (4) step("count");
        chk("count_first_d0", {28'h0, d0}, 32'd1);
        step("count");
        chk("count_first_sseg0", {24'h0, sseg0}, 32'hF9);
        repeat (35) step("count");
        chk("count_40_d1d0", {24'h0, d1, d0}, 32'h10);
        step("count");
        chk("count_40_sseg", {16'h0, sseg1, sseg0}, 32'hF9C0);

        // Pause at p == 2.
        for (int k = 0; k < 2 * DIV && m_p != 2; k++) step("pre_pause");
        saved = m_cnt;
        go = 1'b0;
        repeat (10) step("pause");
        chk("pause_hold", {16'h0, d3, d2, d1, d0}, {16'h0, bcd(saved)});
        go = 1'b1;
        step("resume");
        chk("resume_1cyc", {16'h0, d3, d2, d1, d0}, {16'h0, bcd(saved)});
        step("resume");
        chk("resume_2cyc", {16'h0, d3, d2, d1, d0}, {16'h0, bcd(saved + 1)});

        // Clear on the cycle a tick is due.
        for (int k = 0; k < 2 * DIV && m_p != DIV - 1; k++) step("pre_clr");
        clr = 1'b1;
        step("clr");
        chk("clr_digits", {16'h0, d3, d2, d1, d0}, 32'h0);
        clr = 1'b0;
        repeat (3) step("post_clr");
        chk("post_clr_3cyc", {28'h0, d0}, 32'd0);
        step("post_clr");
        chk("post_clr_4cyc", {28'h0, d0}, 32'd1);

        // Full rollover from 00.00.
        clr = 1'b1;
        step("pre_roll");
        clr = 1'b0;
        nwrap = 0;
        for (int k = 0; k < 40000; k++) begin
            step("roll");
            if (wrap) nwrap++;
        end
        chk("roll_wrap_count", nwrap, 1);
        chk("roll_wrap_last", {31'h0, wrap}, 32'd1);
        chk("roll_digits", {16'h0, d3, d2, d1, d0}, 32'h0);
        step("roll");
        chk("roll_sseg2", {24'h0, sseg2}, 32'h40);

        // Randomized go/clr.
        for (int k = 0; k < 3000; k++) begin
            go  = ($urandom_range(0, 9) != 0);
            clr = ($urandom_range(0, 199) == 0);
            step("rand");
        end

        // Asynchronous reset at 12.34 between clock edges.
        go  = 1'b1;
        clr = 1'b1;
        step("pre_mid");
        clr = 1'b0;
        for (int k = 0; k < 6000 && m_cnt != 1234; k++) step("to_1234");
        chk("reach_1234", {16'h0, d3, d2, d1, d0}, 32'h1234);
        #4;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("mid_reset_async");
        step("mid_reset");
        reset = 1'b0;
        for (int k = 0; k < 200; k++) begin
            go = ($urandom_range(0, 3) != 0);
            step("after_reset");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
